// File: rtl/t03_player_anim_pkg.sv
// Shared types and constants for the player animation controller and sprite LUT.
package t03_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK_A,
    WALK_B,
    ATTACK
  } anim_state_t;

  localparam logic [1:0] SPR_STAND  = 2'd0;
  localparam logic [1:0] SPR_STEP   = 2'd1;
  localparam logic [1:0] SPR_ATTACK = 2'd2;

  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_ATK   = 2;

  function automatic logic [1:0] sprite_of(anim_state_t s);
    logic [1:0] spr;
    unique case (s)
      WALK_A:  spr = SPR_STEP;
      ATTACK:  spr = SPR_ATTACK;
      default: spr = SPR_STAND;
    endcase
    return spr;
  endfunction

endpackage

// File: rtl/t03_player_anim_fsm.sv
// One player's animation FSM: pose counter, attack edge detect and facing register.
module t03_player_anim_fsm
  import t03_pkg::*;
#(
  parameter int unsigned WALK_FRAMES   = 8,
  parameter int unsigned ATTACK_FRAMES = 12,
  parameter logic        facing_rst    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [2:0] btn,
  output logic [1:0] sprite,
  output logic       facing_left
);

  localparam logic [7:0] WalkLast = 8'(WALK_FRAMES - 1);
  localparam logic [7:0] AtkLast  = 8'(ATTACK_FRAMES - 1);

  anim_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        atk_prev_q, atk_prev_d;
  logic        left_q, left_d;
  logic        move;
  logic        atk_edge;

  assign move     = btn[BTN_LEFT] ^ btn[BTN_RIGHT];
  assign atk_edge = btn[BTN_ATK] & ~atk_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      atk_prev_q <= 1'b0;
      left_q     <= facing_rst;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      atk_prev_q <= atk_prev_d;
      left_q     <= left_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    atk_prev_d = atk_prev_q;
    left_d     = left_q;
    if (frame_tick) begin
      atk_prev_d = btn[BTN_ATK];
      // An attack runs to completion; buttons (including facing) are ignored meanwhile.
      if (state_q == ATTACK) begin
        if (cnt_q == AtkLast) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else if (atk_edge) begin
        state_d = ATTACK;
        cnt_d   = '0;
      end else if (move) begin
        left_d = btn[BTN_LEFT];
        if (state_q == IDLE) begin
          state_d = WALK_A;
          cnt_d   = '0;
        end else if (cnt_q == WalkLast) begin
          state_d = (state_q == WALK_A) ? WALK_B : WALK_A;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  assign sprite      = sprite_of(state_q);
  assign facing_left = left_q;

endmodule

// File: rtl/t03_player_anim.sv
// Two-player animation controller: drives sprite selects and facing bits for the sprite LUT.
module t03_player_anim
  import t03_pkg::*;
#(
  parameter int unsigned WALK_FRAMES   = 8,
  parameter int unsigned ATTACK_FRAMES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [2:0] p1_btn,
  input  logic [2:0] p2_btn,
  output logic [3:0] player_state,
  output logic       p1Left,
  output logic       p2Left
);

  logic [1:0] p1_sprite;
  logic [1:0] p2_sprite;

  // Players start facing each other.
  t03_player_anim_fsm #(
    .WALK_FRAMES  (WALK_FRAMES),
    .ATTACK_FRAMES(ATTACK_FRAMES),
    .facing_rst   (1'b0)
  ) u_p1 (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn        (p1_btn),
    .sprite     (p1_sprite),
    .facing_left(p1Left)
  );

  t03_player_anim_fsm #(
    .WALK_FRAMES  (WALK_FRAMES),
    .ATTACK_FRAMES(ATTACK_FRAMES),
    .facing_rst   (1'b1)
  ) u_p2 (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn        (p2_btn),
    .sprite     (p2_sprite),
    .facing_left(p2Left)
  );

  assign player_state = {p2_sprite, p1_sprite};

endmodule

// File: tb/tb_t03_player_anim.sv
// Scoreboard bench for t03_player_anim: random and directed ticks against a tick-count model.
module tb_t03_player_anim;

  localparam int WALK = 8;
  localparam int ATK  = 12;
  localparam logic [5:0] RST_VAL = 6'b10_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [2:0] p1_btn = 3'b000;
  logic [2:0] p2_btn = 3'b000;
  logic [3:0] player_state;
  logic       p1Left;
  logic       p2Left;

  t03_player_anim #(
    .WALK_FRAMES  (WALK),
    .ATTACK_FRAMES(ATK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .p1_btn      (p1_btn),
    .p2_btn      (p2_btn),
    .player_state(player_state),
    .p1Left      (p1Left),
    .p2Left      (p2Left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: remaining attack ticks, ticks spent walking, previous attack level, facing.
  int atk_left[2];
  int walk_n[2];
  bit prev_atk[2];
  bit face[2];

  logic [5:0] exp_q[$];
  logic [5:0] last_exp = RST_VAL;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      atk_left[p] = 0;
      walk_n[p]   = 0;
      prev_atk[p] = 1'b0;
    end
    face[0] = 1'b0;
    face[1] = 1'b1;
  endtask

  task automatic model_step(input int p, input logic [2:0] b);
    bit atk = b[2];
    bit mv  = b[0] ^ b[1];
    if (atk_left[p] > 0) begin
      atk_left[p]--;
    end else if (atk && !prev_atk[p]) begin
      atk_left[p] = ATK;
      walk_n[p]   = 0;
    end else if (mv) begin
      face[p] = b[0];
      walk_n[p]++;
    end else begin
      walk_n[p] = 0;
    end
    prev_atk[p] = atk;
  endtask

  function automatic logic [1:0] model_sprite(input int p);
    if (atk_left[p] > 0) return 2'd2;
    if (walk_n[p] > 0 && (((walk_n[p] - 1) / WALK) % 2) == 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [5:0] model_out();
    return {face[1], face[0], model_sprite(1), model_sprite(0)};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got {p2Left,p1Left,state}=%b want %b", name, $time, got, want);
    end
  endtask

  // One frame tick, then `gap` non-tick clocks with button noise.
  task automatic do_tick(input logic [2:0] a, input logic [2:0] b, input int gap);
    @(negedge clk);
    p1_btn = a;
    p2_btn = b;
    frame_tick = 1'b1;
    model_step(0, a);
    model_step(1, b);
    exp_q.push_back(model_out());
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      p1_btn = 3'($urandom);
      p2_btn = 3'($urandom);
    end
  endtask

  task automatic ticks(input int n, input logic [2:0] a, input logic [2:0] b);
    for (int i = 0; i < n; i++) do_tick(a, b, 1);
  endtask

  // Monitor: outputs must move only one clock after a tick, and hold otherwise.
  initial begin
    logic t;
    forever begin
      @(posedge clk);
      t = frame_tick && !rst;
      #1;
      if (t) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow t=%0t got none want an entry", $time);
        end else begin
          last_exp = exp_q.pop_front();
          check("tick_update", {p2Left, p1Left, player_state}, last_exp);
        end
      end else begin
        check("hold", {p2Left, p1Left, player_state}, last_exp);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Walk right, then release.
    ticks(20, 3'b010, 3'b000);
    ticks(1, 3'b000, 3'b000);

    // P2 turns right, then attacks; left pressed during the attack is ignored.
    ticks(2, 3'b000, 3'b010);
    ticks(1, 3'b000, 3'b100);
    ticks(12, 3'b000, 3'b001);
    ticks(2, 3'b000, 3'b000);

    // Held attack fires once; release and re-press fires again.
    ticks(30, 3'b100, 3'b000);
    ticks(1, 3'b000, 3'b000);
    ticks(14, 3'b100, 3'b000);
    ticks(1, 3'b000, 3'b000);

    // Face left, then both directions, then attack+right while P2 walks left.
    ticks(2, 3'b001, 3'b000);
    ticks(3, 3'b011, 3'b000);
    ticks(16, 3'b110, 3'b001);
    ticks(1, 3'b000, 3'b000);

    // Asynchronous reset in the middle of an attack.
    ticks(4, 3'b100, 3'b100);
    @(negedge clk);
    frame_tick = 1'b0;
    p1_btn = 3'b000;
    p2_btn = 3'b000;
    #2;
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    last_exp = RST_VAL;
    #1;
    check("async_reset", {p2Left, p1Left, player_state}, RST_VAL);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ticks(5, 3'b000, 3'b000);

    // Tick gating: buttons churn with no frame tick.
    ticks(3, 3'b001, 3'b010);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      p1_btn = 3'($urandom);
      p2_btn = 3'($urandom);
    end

    // Random phase with back-to-back ticks allowed.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] a;
      logic [2:0] b;
      a = 3'($urandom);
      b = 3'($urandom);
      if ($urandom_range(0, 3) != 0) a[2] = 1'b0;
      if ($urandom_range(0, 3) != 0) b[2] = 1'b0;
      do_tick(a, b, $urandom_range(0, 2));
    end

    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t03_player_anim.md
# t03_player_anim

Per-player animation controller for the two-player fighter. It turns debounced button levels into the sprite-select and facing signals consumed by the player sprite LUT: `player_state[1:0]`/`[3:2]`, `p1Left` and `p2Left`. Everything advances once per video frame on `frame_tick`, so animation speed does not depend on the clock rate. It sits between the input synchroniser and the sprite LUT in the render path.

## Interface
- `WALK_FRAMES`, default 8: frame ticks each walk pose is held; legal range 1..255.
- `ATTACK_FRAMES`, default 12: frame ticks the attack pose is held; legal range 1..255.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset. Reset is asynchronous and active-high; one clock domain.
- `frame_tick` input, 1 bit: single-cycle strobe, once per video frame.
- `p1_btn` input, 3 bits: player-1 levels `{attack, right, left}`, already synchronised.
- `p2_btn` input, 3 bits: player-2 levels, same encoding.
- `player_state` output, 4 bits: `[1:0]` is the P1 sprite select, `[3:2]` is the P2 sprite select.
- `p1Left` output, 1 bit: P1 faces left.
- `p2Left` output, 1 bit: P2 faces left.

## Operation
- Each player runs an identical, independent FSM with states IDLE, WALK_A, WALK_B and ATTACK.
- Sprite select per state: IDLE → 0, WALK_A → 1, WALK_B → 0, ATTACK → 2. The value 3 is never produced.
- Buttons are sampled only on `frame_tick` cycles. With `frame_tick` low, all state is held.
- `move` = left XOR right. Pressing both buttons, or neither, means no move.
- `atk_edge` = attack high on this tick AND attack low on the previous tick. The `atk_prev` register updates only on ticks.
- Transitions on a tick, in priority order:
  - In ATTACK: `cnt == ATTACK_FRAMES-1` → IDLE with `cnt`=0. Otherwise `cnt++`. Buttons are ignored, including facing and a new `atk_edge`.
  - Else if `atk_edge`: → ATTACK with `cnt`=0.
  - Else if `move`: IDLE → WALK_A with `cnt`=0. In WALK_A or WALK_B: `cnt == WALK_FRAMES-1` toggles A↔B with `cnt`=0; otherwise `cnt++`.
  - Else: → IDLE with `cnt`=0.
- Facing: on a tick outside ATTACK with `move` true, `xLeft` ← left button. With no move, facing is held.
- An attack held through the end of ATTACK does not retrigger; the button must be released for one tick first.
- `cnt` is 8 bits. It is compared against `PARAM-1` and never wraps in legal operation.

## Timing
- All outputs are registered and change only on the `clk` edge where `frame_tick`=1. Latency from the sampled tick is one clock.
- Reset values: `player_state`=4'b0000, `p1Left`=0, `p2Left`=1 (players face each other), both FSMs in IDLE, `cnt`=0, `atk_prev`=0.
- Reset asserted mid-animation forces the reset values immediately, with no wait for a tick.
- An attack lasts exactly `ATTACK_FRAMES` ticks: sprite 2 is visible from tick t+1 through tick t+`ATTACK_FRAMES`, and sprite 0 from the following tick.
- During a continuous walk, each pose lasts `WALK_FRAMES` ticks. The first WALK_A pose appears one clock after the tick that sees `move`.
- If `frame_tick` is asserted on consecutive cycles, each cycle counts as a tick; no error is flagged.

## Structure
- Shared package `t03_pkg` holds:
  - the state enum `anim_state_t` {IDLE, WALK_A, WALK_B, ATTACK};
  - sprite-select constants `SPR_STAND`=0, `SPR_STEP`=1, `SPR_ATTACK`=2, which the sprite LUT also uses;
  - button bit positions `BTN_LEFT`=0, `BTN_RIGHT`=1, `BTN_ATK`=2.
- One sub-module, `t03_player_anim_fsm`:
  - contents: one player's FSM, counter, `atk_prev` and facing register;
  - `facing_rst` parameter sets the facing reset value;
  - instantiated twice, with P1 `facing_rst`=0 and P2 `facing_rst`=1.
- The top level only concatenates the two selects into `player_state` and routes the facing bits.

## Test plan
- **Reset:** assert `rst` mid-ATTACK, asynchronously between clock edges → `player_state`=0, `p1Left`=0, `p2Left`=1 immediately; stays there for 5 ticks with no buttons.
- **Walk:** P1 right held for 20 ticks (`WALK_FRAMES`=8) → `[1:0]` reads 1 for 8 ticks, 0 for 8, then 1; `p1Left`=0. Release → 0 on the next tick.
- **Attack timing:** P2 attack pulse of 1 tick (`ATTACK_FRAMES`=12) → `[3:2]`=2 for exactly 12 ticks, then 0. Pressing left during the attack leaves `p2Left` unchanged.
- **No retrigger:** P1 attack held for 30 ticks → exactly one 12-tick attack. Release one tick, then press → a second attack.
- **Simultaneous inputs:** P1 left+right together → IDLE, facing unchanged. P1 attack plus right on the same tick → ATTACK, `p1Left` unchanged. P2 walking left at the same time → `p2Left`=1 and P2 sequence unaffected.
- **Tick gating:** buttons toggled with `frame_tick` low for 100 clocks → no output change.
